// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the parametrised iterative multiplier.
//   state_t   : controller states (IDLE, RUN, DONE)
//   MAX_WIDTH : widest operand the magnitude helper supports (exclusive)
//   twos_mag  : two's-complement magnitude of the low w bits of a value
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_WIDTH = 256;

  // The caller zero-extends a w-bit operand into v. When bit w-1 is set the
  // full-width negation is returned; its low w bits are the magnitude. The
  // most-negative value maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAX_WIDTH-1:0] twos_mag(input logic [MAX_WIDTH-1:0] v,
                                                    input int unsigned        w);
    logic [MAX_WIDTH-1:0] sign_sh;
    logic [MAX_WIDTH-1:0] m;
    sign_sh = v >> (w - 1);
    m       = v;
    if (sign_sh[0]) m = ~v + MAX_WIDTH'(1);
    return m;
  endfunction

endpackage

// File: rtl/multiplier_step.sv
// One radix step of the shift-and-add multiplier (purely combinational).
//   acc      : running 2*WIDTH-bit accumulator
//   mcand    : multiplicand magnitude
//   slice    : low BITS_PER_CYCLE bits of the remaining multiplier
//   pos      : bit position of the slice within the original multiplier
//   acc_next : acc + (mcand * slice) << pos
module multiplier_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        acc,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  input  logic [$clog2(WIDTH)-1:0]  pos,
  output logic [2*WIDTH-1:0]        acc_next
);

  localparam int unsigned AW = 2 * WIDTH;

  logic [AW-1:0] partial;

  always_comb begin
    partial  = AW'(mcand) * AW'(slice);
    acc_next = acc + (partial << pos);
  end

endmodule

// File: rtl/multiplier_iterative_param.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier, BITS_PER_CYCLE multiplier
// bits retired per cycle, signed or unsigned per operation, with a
// valid/ready handshake on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   valid_in / ready_in : operand handshake (signed_mode, a, b)
//   valid_out/ready_out : result handshake (r held until taken)
//   busy                : high while iterating
module multiplier_iterative_param
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [2*WIDTH-1:0] r,
  output logic               busy
);

  localparam int unsigned ITER = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned PW   = $clog2(WIDTH);
  localparam int unsigned AW   = 2 * WIDTH;

  if (WIDTH < 2 || WIDTH >= MAX_WIDTH) begin : g_bad_width
    $fatal(1, "multiplier_iterative_param: WIDTH out of range");
  end
  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
    $fatal(1, "multiplier_iterative_param: WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  state_t               state, state_next;
  logic [CW-1:0]        cnt;
  logic [PW-1:0]        pos;
  logic [AW-1:0]        acc, acc_next;
  logic [WIDTH-1:0]     mcand, mplier, a_mag, b_mag;
  logic                 neg;
  logic                 accept;
  logic [MAX_WIDTH-1:0] a_ext, b_ext;
  logic                 unused_ext_bits;

  assign ready_in  = (state == IDLE) || (state == DONE && ready_out);
  assign accept    = valid_in && ready_in;
  assign busy      = (state == RUN);
  assign valid_out = (state == DONE);

  always_comb begin
    a_ext = twos_mag(MAX_WIDTH'(a), WIDTH);
    b_ext = twos_mag(MAX_WIDTH'(b), WIDTH);
    a_mag = signed_mode ? a_ext[WIDTH-1:0] : a;
    b_mag = signed_mode ? b_ext[WIDTH-1:0] : b;
  end

  assign unused_ext_bits = ^{a_ext[MAX_WIDTH-1:WIDTH], b_ext[MAX_WIDTH-1:WIDTH]};

  multiplier_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .slice    (mplier[BITS_PER_CYCLE-1:0]),
    .pos      (pos),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (valid_in) state_next = RUN;
      RUN:     if (cnt == CW'(1)) state_next = DONE;
      DONE:    if (ready_out) state_next = valid_in ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pos    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      r      <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc    <= '0;
      cnt    <= CW'(ITER);
      pos    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mplier <= mplier >> BITS_PER_CYCLE;
      cnt    <= cnt - CW'(1);
      pos    <= pos + PW'(BITS_PER_CYCLE);
      // Final step: the sum from this cycle goes straight into r with the
      // sign applied, so the result lands on the same edge as DONE.
      if (cnt == CW'(1)) r <= neg ? (~acc_next + AW'(1)) : acc_next;
    end
  end

endmodule

// File: tb/tb_multiplier_iterative_param.sv
module tb_multiplier_iterative_param;

  logic        clk;
  logic        rst_n;
  logic        valid_in, ready_in, signed_mode, valid_out, ready_out, busy;
  logic [31:0] a, b;
  logic [63:0] r;
  logic        valid_in_4, ready_in_4, signed_mode_4, valid_out_4, ready_out_4, busy_4;
  logic [31:0] a_4, b_4;
  logic [63:0] r_4;

  int total = 0;
  int bad   = 0;

  multiplier_iterative_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .signed_mode(signed_mode), .a(a), .b(b), .valid_out(valid_out),
    .ready_out(ready_out), .r(r), .busy(busy)
  );

  multiplier_iterative_param #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in_4), .ready_in(ready_in_4),
    .signed_mode(signed_mode_4), .a(a_4), .b(b_4), .valid_out(valid_out_4),
    .ready_out(ready_out_4), .r(r_4), .busy(busy_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer multiplication of the operands as interpreted
  // by the mode.
  function automatic logic [63:0] ref_mul(input bit sm, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = 64'(x);
    uy = 64'(y);
    return ux * uy;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 15))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Waits (bounded) for valid_out of the WIDTH=32/BPC=1 instance; lat=-1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid_out) begin lat = k; break; end
    end
  endtask

  // Issues one operation from IDLE, returns product, latency and busy cycles,
  // then consumes the result.
  task automatic run_op(input bit sm, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] res, output int lat, output int busy_cycles);
    valid_in = 1'b1; signed_mode = sm; a = x; b = y; ready_out = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0; a = '0; b = '0;
    busy_cycles = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid_out) begin lat = k; break; end
      if (busy) busy_cycles++;
    end
    res = r;
    ready_out = 1'b1;
    @(posedge clk); #1;
    ready_out = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 0; signed_mode = 0; a = '0; b = '0; ready_out = 0;
    valid_in_4 = 0; signed_mode_4 = 0; a_4 = '0; b_4 = '0; ready_out_4 = 0;
    #12;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (r !== 64'd0) begin bad++; $display("FAIL reset_r: got %h want 0", r); end
    total++; if (r_4 !== 64'd0 || valid_out_4 !== 1'b0) begin bad++; $display("FAIL reset_dut4: r=%h v=%b want 0/0", r_4, valid_out_4); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL reset_ready_in: got %b want 1", ready_in); end
  endtask

  task automatic test_unsigned_max();
    logic [63:0] res; int lat, bc;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bc);
    total++; if (res !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL umax_product: got %h want fffffffe00000001", res); end
    total++; if (lat != 32) begin bad++; $display("FAIL umax_latency: got %0d want 32", lat); end
    total++; if (bc != 32) begin bad++; $display("FAIL umax_busy_cycles: got %0d want 32", bc); end
    total++; if (valid_out !== 1'b0 || ready_in !== 1'b1) begin bad++; $display("FAIL umax_after_consume: valid_out=%b ready_in=%b want 0/1", valid_out, ready_in); end
  endtask

  task automatic test_signed();
    logic [63:0] res; int lat, bc;
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bc);
    total++; if (res !== 64'd1 || lat != 32) begin bad++; $display("FAIL signed_m1_m1: got %h lat %0d want 1 lat 32", res, lat); end
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, res, lat, bc);
    total++; if (res !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL signed_minneg_sq: got %h want 4000000000000000", res); end
    run_op(1'b1, 32'hFFFF_FFF9, 32'd6, res, lat, bc);
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFD6) begin bad++; $display("FAIL signed_m7_6: got %h want ffffffffffffffd6", res); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] hold; int lat;
    valid_in = 1; signed_mode = 0; a = 32'd100; b = 32'd200; ready_out = 0;
    @(posedge clk); #1;
    valid_in = 0;
    wait_valid(lat);
    total++; if (lat != 32 || r !== 64'd20000) begin bad++; $display("FAIL bp_first: got %h lat %0d want 20000 lat 32", r, lat); end
    hold = r;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      total++;
      if (valid_out !== 1'b1 || r !== hold || ready_in !== 1'b0) begin
        bad++; $display("FAIL bp_hold: cyc %0d valid_out=%b r=%h ready_in=%b want 1/%h/0", k, valid_out, r, ready_in, hold);
      end
    end
    ready_out = 1; valid_in = 1; a = 32'd3; b = 32'd5; signed_mode = 0;
    #1;
    total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL b2b_ready_in: got %b want 1", ready_in); end
    @(posedge clk); #1;
    valid_in = 0; ready_out = 0; a = '0; b = '0;
    total++; if (valid_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_no_bubble: valid_out=%b busy=%b want 0/1", valid_out, busy); end
    wait_valid(lat);
    total++; if (lat != 32 || r !== 64'd15) begin bad++; $display("FAIL b2b_product: got %h lat %0d want 15 lat 32", r, lat); end
    ready_out = 1;
    @(posedge clk); #1;
    ready_out = 0;
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] res; int lat, bc;
    valid_in = 1; signed_mode = 0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    valid_in = 0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0 || busy !== 1'b0 || r !== 64'd0) begin
      bad++; $display("FAIL midrun_reset: valid_out=%b busy=%b r=%h want 0/0/0", valid_out, busy, r);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 32'd2, 32'd3, res, lat, bc);
    total++; if (res !== 64'd6 || lat != 32) begin bad++; $display("FAIL midrun_fresh_op: got %h lat %0d want 6 lat 32", res, lat); end
  endtask

  task automatic test_radix();
    logic [31:0] xs[2];
    logic [31:0] ys[2];
    logic [63:0] ex[2];
    int lat;
    xs[0] = 32'd123456; ys[0] = 32'd654321;      ex[0] = 64'd80779853376;
    xs[1] = 32'd0;      ys[1] = 32'hFFFF_FFFF;   ex[1] = 64'd0;
    for (int i = 0; i < 2; i++) begin
      valid_in_4 = 1; signed_mode_4 = 0; a_4 = xs[i]; b_4 = ys[i]; ready_out_4 = 0;
      @(posedge clk); #1;
      valid_in_4 = 0;
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk); #1;
        if (valid_out_4) begin lat = k; break; end
      end
      total++; if (lat != 8) begin bad++; $display("FAIL radix_latency[%0d]: got %0d want 8", i, lat); end
      total++; if (r_4 !== ex[i]) begin bad++; $display("FAIL radix_product[%0d]: got %h want %h", i, r_4, ex[i]); end
      ready_out_4 = 1;
      @(posedge clk); #1;
      ready_out_4 = 0;
      total++; if (valid_out_4 !== 1'b0 || busy_4 !== 1'b0) begin bad++; $display("FAIL radix_consume[%0d]: valid_out=%b busy=%b want 0/0", i, valid_out_4, busy_4); end
    end
  endtask

  task automatic test_random();
    bit          have;
    bit          sm;
    logic [31:0] x, y;
    logic [63:0] exp, hold;
    int          lat, stall;
    have = 0;
    for (int i = 0; i < 1000; i++) begin
      sm  = 1'($urandom_range(0, 1));
      x   = pick();
      y   = pick();
      exp = ref_mul(sm, x, y);
      if (!have) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      valid_in = 1; signed_mode = sm; a = x; b = y; ready_out = have;
      #1;
      total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL rnd_ready_in: op %0d got %b want 1", i, ready_in); end
      @(posedge clk); #1;
      valid_in = 0; ready_out = 0;
      a = $urandom; b = $urandom; signed_mode = 1'($urandom_range(0, 1));
      have = 0;
      wait_valid(lat);
      total++; if (lat != 32) begin bad++; $display("FAIL rnd_latency: op %0d got %0d want 32", i, lat); end
      total++; if (r !== exp) begin bad++; $display("FAIL rnd_product: op %0d sm=%0d a=%h b=%h got %h want %h", i, sm, x, y, r, exp); end
      hold  = r;
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        @(posedge clk); #1;
        total++; if (valid_out !== 1'b1 || r !== hold) begin bad++; $display("FAIL rnd_hold: op %0d valid_out=%b r=%h want 1/%h", i, valid_out, r, hold); end
      end
      if ($urandom_range(0, 1) == 1) begin
        ready_out = 1;
        @(posedge clk); #1;
        ready_out = 0;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rnd_consume: op %0d valid_out=%b want 0", i, valid_out); end
      end else begin
        have = 1;
      end
    end
    if (have) begin
      ready_out = 1;
      @(posedge clk); #1;
      ready_out = 0;
    end
    total++; if (valid_out !== 1'b0 || busy !== 1'b0 || ready_in !== 1'b1) begin
      bad++; $display("FAIL rnd_final_idle: valid_out=%b busy=%b ready_in=%b want 0/0/1", valid_out, busy, ready_in);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_back_to_back();
    test_reset_mid_run();
    test_radix();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplier_iterative_param.md
Name: multiplier_iterative_param

Overview:
- Parametrised successor to the team's fixed 32-bit iterative multiplier. Computes a WIDTH x WIDTH -> 2*WIDTH product over several cycles.
- Adds the following over the fixed version:
  - configurable radix (BITS_PER_CYCLE bits of the multiplier consumed per cycle);
  - per-operation signed/unsigned mode;
  - a full valid/ready handshake on both input and output, so results are held under backpressure.
- Sits in the functional-unit layer beside the other arithmetic blocks and is driven by the execute stage.

Parameters:
- WIDTH, 32, operand width in bits. Must be >= 2.
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle. WIDTH % BITS_PER_CYCLE must be 0, otherwise elaboration stops with $fatal.
- ITER (localparam), WIDTH/BITS_PER_CYCLE, number of RUN cycles.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- valid_in, input, 1, operands and mode are valid.
- ready_in, output, 1, block can accept an operation this cycle.
- signed_mode, input, 1, 1 = two's-complement operands; 0 = unsigned.
- a, input, WIDTH, multiplicand.
- b, input, WIDTH, multiplier.
- valid_out, output, 1, r holds a finished product.
- ready_out, input, 1, consumer takes r this cycle.
- r, output, 2*WIDTH, product.
- busy, output, 1, high while in RUN.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-RUN):
  - state goes to IDLE;
  - valid_out = 0, busy = 0, r = 0, counter = 0;
  - the in-flight operation is discarded with no partial output.
  - ready_in is 1 once rst_n is high.
- States: IDLE, RUN, DONE.
- Handshake:
  - Transfer occurs on a rising edge with valid_in && ready_in.
  - ready_in = (state == IDLE) || (state == DONE && ready_out). It is combinational from state and ready_out; there is no path from valid_in.
- IDLE -> RUN on accept:
  - Capture signed_mode and the sign of each operand.
  - Capture the magnitudes |a| and |b|; in unsigned mode these are the raw values.
  - Set the accumulator to 0 and counter = ITER.
  - Operands may change after the accepting edge without effect.
- RUN, each cycle:
  - Add (multiplicand * low BITS_PER_CYCLE bits of multiplier), shifted to the current position, into the 2*WIDTH accumulator.
  - Shift the multiplier right by BITS_PER_CYCLE and decrement the counter.
  - valid_in is ignored (ready_in = 0).
- RUN -> DONE on the edge where counter goes 1 -> 0:
  - r is registered as the accumulator, negated when signed_mode && (sign_a XOR sign_b).
  - valid_out rises on the ITER-th rising edge after the accepting edge. Defaults give 32 cycles; BITS_PER_CYCLE = 4 gives 8.
- DONE:
  - r and valid_out are held stable until ready_out = 1.
  - ready_out = 1 and valid_in = 0: go to IDLE, valid_out = 0.
  - ready_out = 1 and valid_in = 1 on the same edge: the result is consumed and the new operation is accepted; go directly to RUN, valid_out = 0. No bubble cycle.
- Width rules:
  - The unsigned product always fits in 2*WIDTH bits.
  - The signed magnitude of the most-negative operand is 2^(WIDTH-1). It is representable as an unsigned WIDTH-bit value, so (-2^(W-1))^2 = 2^(2W-2) fits without overflow.
  - Magnitude logic operates on WIDTH-bit unsigned values; the accumulator is 2*WIDTH bits.
- A zero operand still takes ITER cycles; there is no early termination.
- r keeps its last value in IDLE and RUN. Consumers qualify r with valid_out.

Decomposition:
- Package multiplier_pkg:
  - state typedef (enum logic[1:0] {IDLE, RUN, DONE});
  - function computing the two's-complement magnitude of a WIDTH-bit value.
- Sub-module multiplier_step: combinational; takes accumulator, multiplicand, multiplier slice and bit position, and returns the next accumulator. Parametrised by WIDTH and BITS_PER_CYCLE. Instantiated once.

Test Plan:
- Unsigned, WIDTH = 32, BPC = 1: a = 0xFFFFFFFF, b = 0xFFFFFFFF, ready_out = 1 -> r = 0xFFFFFFFE00000001; valid_out rises exactly 32 edges after acceptance, busy is high for those 32 cycles.
- Signed: a = -1, b = -1 -> r = 1. a = 0x80000000, b = 0x80000000 -> r = 0x4000000000000000. a = -7, b = 6 -> r = 0xFFFFFFFFFFFFFFD6.
- Backpressure: hold ready_out = 0 for 10 cycles after valid_out -> r and valid_out stay stable and ready_in = 0. Then raise ready_out together with valid_in (a = 3, b = 5) -> back-to-back accept, next r = 15 with no idle cycle.
- Radix: BPC = 4, unsigned a = 123456, b = 654321 -> r = 80779853376 after 8 cycles. Also a = 0, b = 0xFFFFFFFF -> r = 0 after 8 cycles.
- Reset mid-operation: assert rst_n = 0 asynchronously 10 cycles into RUN -> valid_out, busy and r go to 0 immediately. After release, a fresh 2 * 3 completes with r = 6.
- Random: 1000 mixed-mode random operations with random ready_out stalls -> every r matches the signed or unsigned reference product, and no result is lost or duplicated.
